demux1_5: RTL and testbench

Registered 1-to-5 demultiplexer with valid/ready handshaking. It steers one SZE-bit input word to one of five output lanes chosen by a 3-bit select, and is the distributing counterpart of the team's 5:1 lane multiplexer. Each lane has a one-entry holding register, so a stalled lane blocks only traffic addressed to it. Out-of-range selects are discarded and counted for debug.

---
 rtl/demux1_5.sv | 125 ++++++++++++
 tb/tb_demux1_5.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/demux1_5.sv
// demux1_5 : registered 1-to-5 demultiplexer with valid/ready handshaking.
// Each output lane owns a one-entry holding register, so a stalled lane only
// blocks words addressed to it. Words with an out-of-range select (5-7) are
// accepted, discarded, and counted in a saturating debug counter.
module demux1_5 #(
   parameter int SZE = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [SZE-1:0] in_data,
   input  logic [2:0]     in_sel,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [SZE-1:0] out0,
   output logic [SZE-1:0] out1,
   output logic [SZE-1:0] out2,
   output logic [SZE-1:0] out3,
   output logic [SZE-1:0] out4,
   output logic [SZE-1:0] outbar0,
   output logic [SZE-1:0] outbar1,
   output logic [SZE-1:0] outbar2,
   output logic [SZE-1:0] outbar3,
   output logic [SZE-1:0] outbar4,
   output logic [4:0]     out_valid,
   input  logic [4:0]     out_ready,
   output logic           drop_pulse,
   output logic [7:0]     drop_cnt
);

   localparam int          NUM_LANES = 5;
   localparam logic [7:0]  CNT_MAX   = 8'hFF;

   logic [SZE-1:0]       r_data [NUM_LANES];
   logic [NUM_LANES-1:0] r_valid;
   logic                 r_drop_pulse;
   logic [7:0]           r_drop_cnt;

   logic                 w_sel_ok;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_drop;
   logic [NUM_LANES-1:0] w_load;

   assign w_sel_ok = (in_sel < 3'd5);

   // Input readiness: a valid lane may accept when empty or draining this cycle;
   // invalid selects are always accepted so they can be discarded.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      w_ready = 1'b1;
      if (w_sel_ok) begin
         case (in_sel)
            3'd0:    w_ready = !r_valid[0] || out_ready[0];
            3'd1:    w_ready = !r_valid[1] || out_ready[1];
            3'd2:    w_ready = !r_valid[2] || out_ready[2];
            3'd3:    w_ready = !r_valid[3] || out_ready[3];
            3'd4:    w_ready = !r_valid[4] || out_ready[4];
            default: w_ready = 1'b1;
         endcase
      end
   end

   assign w_accept = in_valid && w_ready;
   assign w_drop   = w_accept && !w_sel_ok;

   // One-hot load strobe for the addressed lane.
   always_comb begin
      w_load = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
         w_load[n] = w_accept && w_sel_ok && (in_sel == 3'(n));
      end
   end

   // Lane holding registers: a load wins over a drain, so load+drain keeps the lane full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: lane data is reset too because out0..out4 are directly observable outputs.
         r_valid <= '0;
         for (int n = 0; n < NUM_LANES; n++) begin
            r_data[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_LANES; n++) begin
            if (w_load[n]) begin
               // NOTE: non-blocking assignments keep every register update on the same edge.
               r_data[n]  <= in_data;
               r_valid[n] <= 1'b1;
            end else if (r_valid[n] && out_ready[n]) begin
               r_valid[n] <= 1'b0;
            end
         end
      end
   end

   // Drop tracking: one pulse per discarded word and a saturating count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_drop_pulse <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_drop_pulse <= w_drop;
         if (w_drop && (r_drop_cnt != CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign in_ready   = w_ready;
   assign out_valid  = r_valid;
   assign drop_pulse = r_drop_pulse;
   assign drop_cnt   = r_drop_cnt;

   assign out0 = r_data[0];
   assign out1 = r_data[1];
   assign out2 = r_data[2];
   assign out3 = r_data[3];
   assign out4 = r_data[4];

   assign outbar0 = ~r_data[0];
   assign outbar1 = ~r_data[1];
   assign outbar2 = ~r_data[2];
   assign outbar3 = ~r_data[3];
   assign outbar4 = ~r_data[4];

endmodule

// File: tb/tb_demux1_5.sv
// tb_demux1_5 : directed scenarios followed by random traffic, every cycle
// compared against a lane-level reference model of the demultiplexer.
module tb_demux1_5;

   localparam int SZE = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [SZE-1:0] in_data;
   logic [2:0]     in_sel;
   logic           in_valid;
   logic           in_ready;
   logic [SZE-1:0] o  [5];
   logic [SZE-1:0] ob [5];
   logic [4:0]     out_valid;
   logic [4:0]     out_ready;
   logic           drop_pulse;
   logic [7:0]     drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: what each lane holds, whether it is full, drop bookkeeping.
   int m_data  [5];
   bit m_valid [5];
   bit m_pulse;
   int m_cnt;

   always #5 clk = ~clk;

   demux1_5 #(.SZE(SZE)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
      .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]), .out4(o[4]),
      .outbar0(ob[0]), .outbar1(ob[1]), .outbar2(ob[2]), .outbar3(ob[3]), .outbar4(ob[4]),
      .out_valid(out_valid), .out_ready(out_ready),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, advance model, check registered outputs.
   task automatic step(input bit rst, input bit v, input int sel, input int data, input bit [4:0] rdy);
      bit       exp_rdy;
      bit       acc;
      bit [4:0] ev;
      rst_n     = !rst;
      in_valid  = v;
      in_sel    = sel[2:0];
      in_data   = data[SZE-1:0];
      out_ready = rdy;
      #1;
      exp_rdy = 1'b1;
      if (sel < 5) exp_rdy = !m_valid[sel] || rdy[sel];
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      if (rst) begin
         for (int n = 0; n < 5; n++) begin
            m_data[n]  = 0;
            m_valid[n] = 0;
         end
         m_pulse = 0;
         m_cnt   = 0;
      end else begin
         for (int n = 0; n < 5; n++) begin
            if (acc && sel == n) begin
               m_data[n]  = data % 16;
               m_valid[n] = 1;
            end else if (m_valid[n] && rdy[n]) begin
               m_valid[n] = 0;
            end
         end
         m_pulse = acc && (sel >= 5);
         if (m_pulse && m_cnt < 255) m_cnt++;
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < 5; n++) ev[n] = m_valid[n];
      check("out_valid", 32'(out_valid), 32'(ev));
      for (int n = 0; n < 5; n++) begin
         check($sformatf("out%0d", n), 32'(o[n]), 32'(m_data[n]));
         check($sformatf("outbar%0d", n), 32'(ob[n]), 32'(15 - m_data[n]));
      end
      check("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
      check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
   endtask

   initial begin
      for (int n = 0; n < 5; n++) begin
         m_data[n]  = 0;
         m_valid[n] = 0;
      end
      m_pulse = 0;
      m_cnt   = 0;

      // Reset then idle.
      step(1, 0, 0, 0, 5'h1F);
      step(1, 0, 0, 0, 5'h1F);
      step(0, 0, 0, 0, 5'h1F);
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_outbar0", 32'(ob[0]), 32'hF);

      // Basic routing, all lanes ready.
      step(0, 1, 0, 4'h3, 5'h1F);
      step(0, 1, 1, 4'h5, 5'h1F);
      step(0, 1, 2, 4'h9, 5'h1F);
      check("route_onehot", 32'(out_valid), 32'h04);
      check("route_outbar2", 32'(ob[2]), 32'h6);
      step(0, 1, 3, 4'hA, 5'h1F);
      step(0, 1, 4, 4'hC, 5'h1F);
      step(0, 0, 0, 0, 5'h1F);

      // Backpressure on lane 2.
      step(0, 1, 2, 4'h7, 5'b11011);
      step(0, 1, 2, 4'h8, 5'b11011);
      check("bp_hold", 32'(o[2]), 32'h7);
      step(0, 1, 1, 4'h4, 5'b11011);
      step(0, 1, 2, 4'h8, 5'h1F);
      check("bp_reload", 32'({out_valid[2], o[2]}), 32'h18);
      step(0, 0, 0, 0, 5'h1F);

      // Simultaneous load and drain on lane 3.
      for (int i = 0; i < 7; i++) step(0, 1, 3, i + 1, 5'h1F);
      step(0, 0, 0, 0, 5'h1F);

      // Invalid selects, then saturation of the drop counter.
      step(0, 1, 5, 4'h1, 5'h1F);
      step(0, 1, 6, 4'h2, 5'h1F);
      step(0, 1, 7, 4'h3, 5'h1F);
      check("drop_three", 32'(drop_cnt), 32'd3);
      for (int i = 0; i < 300; i++) step(0, 1, 7, i, 5'h1F);
      step(0, 0, 0, 0, 5'h1F);
      check("drop_sat", 32'(drop_cnt), 32'd255);

      // Reset mid-operation with stalled lanes and a non-zero counter.
      step(1, 0, 0, 0, 5'h1F);
      for (int i = 0; i < 10; i++) step(0, 1, 5, 0, 5'h00);
      step(0, 1, 0, 4'h6, 5'h00);
      step(0, 1, 4, 4'hD, 5'h00);
      check("mid_cnt", 32'(drop_cnt), 32'd10);
      step(1, 0, 0, 0, 5'h00);
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      step(0, 1, 0, 4'hB, 5'h00);
      check("mid_route", 32'(o[0]), 32'hB);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 15), 5'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
